// File: rtl/dma_desc_ctrl.sv
`default_nettype none
// ============================================================================
// dma_desc_ctrl : per-channel DMA descriptor launch/complete controller with
//                 W1C DONE/ERROR status and maskable level interrupt.
// Rev 1.0
// ============================================================================
module dma_desc_ctrl #(
    parameter int N_MM2S          = 3,
    parameter int N_S2MM          = 1,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int AXI_LEN_WIDTH   = 32,
    parameter int AXIS_USER_WIDTH = 65,
    parameter int AXI_TAG_WIDTH   = 8,
    localparam int N_CH           = N_MM2S + N_S2MM,
    localparam int DESC_WIDTH     = AXI_ADDR_WIDTH + AXI_LEN_WIDTH
) (
    input  logic                                      clk,
    input  logic                                      rstn,
    input  logic                                      reg_wr_en,
    input  logic [7:0]                                reg_wr_addr,
    input  logic [AXI_DATA_WIDTH-1:0]                 reg_wr_data,
    input  logic [7:0]                                reg_rd_addr,
    output logic [AXI_DATA_WIDTH-1:0]                 reg_rd_data,
    output logic [N_MM2S-1:0][DESC_WIDTH-1:0]         mm2s_desc,
    output logic [N_MM2S-1:0][AXIS_USER_WIDTH-1:0]    mm2s_user,
    output logic [N_MM2S-1:0]                         mm2s_valid,
    input  logic [N_MM2S-1:0]                         mm2s_ready,
    input  logic [N_MM2S-1:0][3:0]                    mm2s_status_error,
    input  logic [N_MM2S-1:0]                         mm2s_status_valid,
    output logic [N_S2MM-1:0][DESC_WIDTH-1:0]         s2mm_desc,
    output logic [N_S2MM-1:0][AXI_TAG_WIDTH-1:0]      s2mm_tag,
    output logic [N_S2MM-1:0]                         s2mm_valid,
    input  logic [N_S2MM-1:0]                         s2mm_ready,
    input  logic [N_S2MM-1:0][3:0]                    s2mm_status_error,
    input  logic [N_S2MM-1:0]                         s2mm_status_valid,
    output logic                                      irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [7:0] A_START    = 8'h00;
    localparam logic [7:0] A_BUSY     = 8'h01;
    localparam logic [7:0] A_DONE     = 8'h02;
    localparam logic [7:0] A_ERROR    = 8'h03;
    localparam logic [7:0] A_IRQEN    = 8'h04;
    localparam logic [7:0] A_CH_BASE  = 8'h10;
    localparam logic [7:0] A_CH_END   = 8'(16 + 4 * N_CH);
    localparam logic [3:0] C_ERR_ZLEN = 4'hF;

    state_t                      state_q   [N_CH];
    state_t                      state_d   [N_CH];
    logic [AXI_DATA_WIDTH-1:0]   addr_q    [N_CH];
    logic [AXI_DATA_WIDTH-1:0]   addr_d    [N_CH];
    logic [AXI_DATA_WIDTH-1:0]   bytes_q   [N_CH];
    logic [AXI_DATA_WIDTH-1:0]   bytes_d   [N_CH];
    logic [AXI_DATA_WIDTH-1:0]   tuser_q   [N_MM2S];
    logic [AXI_DATA_WIDTH-1:0]   tuser_d   [N_MM2S];
    logic [3:0]                  errcode_q [N_CH];
    logic [3:0]                  errcode_d [N_CH];
    logic [AXI_ADDR_WIDTH-1:0]   sh_addr_q [N_CH];
    logic [AXI_ADDR_WIDTH-1:0]   sh_addr_d [N_CH];
    logic [AXI_LEN_WIDTH-1:0]    sh_len_q  [N_CH];
    logic [AXI_LEN_WIDTH-1:0]    sh_len_d  [N_CH];
    logic [AXIS_USER_WIDTH-1:0]  sh_user_q [N_MM2S];
    logic [AXIS_USER_WIDTH-1:0]  sh_user_d [N_MM2S];
    logic [AXI_TAG_WIDTH-1:0]    tag_cnt_q [N_S2MM];
    logic [AXI_TAG_WIDTH-1:0]    tag_cnt_d [N_S2MM];
    logic [AXI_TAG_WIDTH-1:0]    sh_tag_q  [N_S2MM];
    logic [AXI_TAG_WIDTH-1:0]    sh_tag_d  [N_S2MM];
    logic [N_CH-1:0]             done_q, done_d;
    logic [N_CH-1:0]             error_q, error_d;
    logic [N_CH-1:0]             irq_en_q, irq_en_d;

    logic [N_CH-1:0]             w_ready;
    logic [N_CH-1:0]             w_stat_valid;
    logic [3:0]                  w_stat_err [N_CH];
    logic [N_CH-1:0]             w_start;
    logic [N_CH-1:0]             w_clr_done;
    logic [N_CH-1:0]             w_clr_err;
    logic [N_CH-1:0]             w_busy;
    logic [N_CH-1:0]             w_launch;
    logic [N_CH-1:0]             w_hs;
    logic [N_CH-1:0]             w_set_done;
    logic [N_CH-1:0]             w_set_err;
    logic                        w_wr_ch_hit;
    logic                        w_rd_ch_hit;
    logic [7:0]                  w_wr_ch;
    logic [7:0]                  w_rd_ch;

    assign w_start    = (reg_wr_en && reg_wr_addr == A_START) ? reg_wr_data[N_CH-1:0] : '0;
    assign w_clr_done = (reg_wr_en && reg_wr_addr == A_DONE)  ? reg_wr_data[N_CH-1:0] : '0;
    assign w_clr_err  = (reg_wr_en && reg_wr_addr == A_ERROR) ? reg_wr_data[N_CH-1:0] : '0;

    assign w_wr_ch_hit = (reg_wr_addr >= A_CH_BASE) && (reg_wr_addr < A_CH_END);
    assign w_rd_ch_hit = (reg_rd_addr >= A_CH_BASE) && (reg_rd_addr < A_CH_END);
    assign w_wr_ch     = (reg_wr_addr - A_CH_BASE) >> 2;
    assign w_rd_ch     = (reg_rd_addr - A_CH_BASE) >> 2;

    // MM2S channels occupy indices 0..N_MM2S-1, S2MM channels follow.
    for (genvar i = 0; i < N_MM2S; i++) begin : g_mm2s
        assign w_ready[i]      = mm2s_ready[i];
        assign w_stat_valid[i] = mm2s_status_valid[i];
        assign w_stat_err[i]   = mm2s_status_error[i];
        assign mm2s_valid[i]   = (state_q[i] == ST_REQ);
        assign mm2s_desc[i]    = {sh_len_q[i], sh_addr_q[i]};
        assign mm2s_user[i]    = sh_user_q[i];
    end

    for (genvar j = 0; j < N_S2MM; j++) begin : g_s2mm
        assign w_ready[N_MM2S+j]      = s2mm_ready[j];
        assign w_stat_valid[N_MM2S+j] = s2mm_status_valid[j];
        assign w_stat_err[N_MM2S+j]   = s2mm_status_error[j];
        assign s2mm_valid[j]          = (state_q[N_MM2S+j] == ST_REQ);
        assign s2mm_desc[j]           = {sh_len_q[N_MM2S+j], sh_addr_q[N_MM2S+j]};
        assign s2mm_tag[j]            = sh_tag_q[j];
    end

    // Per-channel FSM. A START can only be taken in IDLE, and completions only
    // occur in WAIT, so a same-cycle START/completion naturally drops the START.
    always_comb begin
        w_launch   = '0;
        w_hs       = '0;
        w_set_done = '0;
        w_set_err  = '0;
        w_busy     = '0;
        for (int c = 0; c < N_CH; c++) begin
            state_d[c]   = state_q[c];
            errcode_d[c] = errcode_q[c];
            sh_addr_d[c] = sh_addr_q[c];
            sh_len_d[c]  = sh_len_q[c];
            w_busy[c]    = (state_q[c] != ST_IDLE);
            case (state_q[c])
                ST_IDLE: begin
                    if (w_start[c]) begin
                        if (AXI_LEN_WIDTH'(bytes_q[c]) == '0) begin
                            w_set_err[c] = 1'b1;
                            errcode_d[c] = C_ERR_ZLEN;
                        end else begin
                            w_launch[c]  = 1'b1;
                            state_d[c]   = ST_REQ;
                            sh_addr_d[c] = AXI_ADDR_WIDTH'(addr_q[c]);
                            sh_len_d[c]  = AXI_LEN_WIDTH'(bytes_q[c]);
                        end
                    end
                end
                ST_REQ: begin
                    if (w_ready[c]) begin
                        w_hs[c]    = 1'b1;
                        state_d[c] = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_stat_valid[c]) begin
                        state_d[c]   = ST_IDLE;
                        errcode_d[c] = w_stat_err[c];
                        if (w_stat_err[c] == 4'h0) begin
                            w_set_done[c] = 1'b1;
                        end else begin
                            w_set_err[c] = 1'b1;
                        end
                    end
                end
                default: state_d[c] = ST_IDLE;
            endcase
        end
    end

    // The tag shown with a descriptor is the counter value at launch time.
    always_comb begin
        for (int m = 0; m < N_MM2S; m++) begin
            sh_user_d[m] = w_launch[m] ? AXIS_USER_WIDTH'(tuser_q[m]) : sh_user_q[m];
        end
        for (int s = 0; s < N_S2MM; s++) begin
            tag_cnt_d[s] = tag_cnt_q[s];
            if (w_hs[N_MM2S+s]) begin
                tag_cnt_d[s] = tag_cnt_q[s] + 1'b1;
            end
            sh_tag_d[s] = w_launch[N_MM2S+s] ? tag_cnt_q[s] : sh_tag_q[s];
        end
    end

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            addr_d[c]  = addr_q[c];
            bytes_d[c] = bytes_q[c];
        end
        for (int m = 0; m < N_MM2S; m++) begin
            tuser_d[m] = tuser_q[m];
        end
        irq_en_d = irq_en_q;
        if (reg_wr_en && reg_wr_addr == A_IRQEN) begin
            irq_en_d = reg_wr_data[N_CH-1:0];
        end
        if (reg_wr_en && w_wr_ch_hit) begin
            for (int c = 0; c < N_CH; c++) begin
                if (w_wr_ch == 8'(c)) begin
                    if (reg_wr_addr[1:0] == 2'd0) addr_d[c]  = reg_wr_data;
                    if (reg_wr_addr[1:0] == 2'd1) bytes_d[c] = reg_wr_data;
                end
            end
            for (int m = 0; m < N_MM2S; m++) begin
                if (w_wr_ch == 8'(m) && reg_wr_addr[1:0] == 2'd2) tuser_d[m] = reg_wr_data;
            end
        end
        // Hardware set is applied after the W1C so it wins on the same bit.
        done_d  = (done_q  & ~w_clr_done) | w_set_done;
        error_d = (error_q & ~w_clr_err)  | w_set_err;
    end

    always_comb begin
        reg_rd_data = '0;
        case (reg_rd_addr)
            A_BUSY:  reg_rd_data = AXI_DATA_WIDTH'(w_busy);
            A_DONE:  reg_rd_data = AXI_DATA_WIDTH'(done_q);
            A_ERROR: reg_rd_data = AXI_DATA_WIDTH'(error_q);
            A_IRQEN: reg_rd_data = AXI_DATA_WIDTH'(irq_en_q);
            default: ;
        endcase
        if (w_rd_ch_hit) begin
            for (int c = 0; c < N_CH; c++) begin
                if (w_rd_ch == 8'(c)) begin
                    case (reg_rd_addr[1:0])
                        2'd0:    reg_rd_data = addr_q[c];
                        2'd1:    reg_rd_data = bytes_q[c];
                        2'd3:    reg_rd_data = AXI_DATA_WIDTH'(errcode_q[c]);
                        default: ;
                    endcase
                end
            end
            for (int m = 0; m < N_MM2S; m++) begin
                if (w_rd_ch == 8'(m) && reg_rd_addr[1:0] == 2'd2) reg_rd_data = tuser_q[m];
            end
        end
    end

    assign irq = |((done_q | error_q) & irq_en_q);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int c = 0; c < N_CH; c++) begin
                state_q[c]   <= ST_IDLE;
                addr_q[c]    <= '0;
                bytes_q[c]   <= '0;
                errcode_q[c] <= '0;
                sh_addr_q[c] <= '0;
                sh_len_q[c]  <= '0;
            end
            for (int m = 0; m < N_MM2S; m++) begin
                tuser_q[m]   <= '0;
                sh_user_q[m] <= '0;
            end
            for (int s = 0; s < N_S2MM; s++) begin
                tag_cnt_q[s] <= '0;
                sh_tag_q[s]  <= '0;
            end
            done_q   <= '0;
            error_q  <= '0;
            irq_en_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            bytes_q   <= bytes_d;
            errcode_q <= errcode_d;
            sh_addr_q <= sh_addr_d;
            sh_len_q  <= sh_len_d;
            tuser_q   <= tuser_d;
            sh_user_q <= sh_user_d;
            tag_cnt_q <= tag_cnt_d;
            sh_tag_q  <= sh_tag_d;
            done_q    <= done_d;
            error_q   <= error_d;
            irq_en_q  <= irq_en_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dma_desc_ctrl.sv
`default_nettype none
// ============================================================================
// tb_dma_desc_ctrl : directed + randomized bench for dma_desc_ctrl against a
//                    transaction-level reference model. Rev 1.0
// ============================================================================
module tb_dma_desc_ctrl;

    localparam int NM    = 3;
    localparam int NS    = 1;
    localparam int NC    = NM + NS;
    localparam int DW    = 32;
    localparam int UW    = 65;
    localparam int TW    = 8;
    localparam int DESCW = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                       rstn;
    logic                       reg_wr_en;
    logic [7:0]                 reg_wr_addr;
    logic [DW-1:0]              reg_wr_data;
    logic [7:0]                 reg_rd_addr;
    logic [DW-1:0]              reg_rd_data;
    logic [NM-1:0][DESCW-1:0]   mm2s_desc;
    logic [NM-1:0][UW-1:0]      mm2s_user;
    logic [NM-1:0]              mm2s_valid;
    logic [NM-1:0]              mm2s_ready;
    logic [NM-1:0][3:0]         mm2s_status_error;
    logic [NM-1:0]              mm2s_status_valid;
    logic [NS-1:0][DESCW-1:0]   s2mm_desc;
    logic [NS-1:0][TW-1:0]      s2mm_tag;
    logic [NS-1:0]              s2mm_valid;
    logic [NS-1:0]              s2mm_ready;
    logic [NS-1:0][3:0]         s2mm_status_error;
    logic [NS-1:0]              s2mm_status_valid;
    logic                       irq;

    dma_desc_ctrl #(
        .N_MM2S(NM), .N_S2MM(NS), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(DW),
        .AXI_LEN_WIDTH(32), .AXIS_USER_WIDTH(UW), .AXI_TAG_WIDTH(TW)
    ) dut (
        .clk(clk), .rstn(rstn),
        .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
        .mm2s_desc(mm2s_desc), .mm2s_user(mm2s_user), .mm2s_valid(mm2s_valid),
        .mm2s_ready(mm2s_ready), .mm2s_status_error(mm2s_status_error),
        .mm2s_status_valid(mm2s_status_valid),
        .s2mm_desc(s2mm_desc), .s2mm_tag(s2mm_tag), .s2mm_valid(s2mm_valid),
        .s2mm_ready(s2mm_ready), .s2mm_status_error(s2mm_status_error),
        .s2mm_status_valid(s2mm_status_valid),
        .irq(irq)
    );

    // Reference model: a channel has an offered descriptor (pend) or an
    // accepted one awaiting status (infl); neither means idle.
    bit [NC-1:0]   m_pend, m_infl, m_done, m_err, m_irqen;
    bit [31:0]     m_addr  [NC];
    bit [31:0]     m_bytes [NC];
    bit [31:0]     m_tuser [NC];
    bit [3:0]      m_code  [NC];
    bit [63:0]     m_desc  [NC];
    bit [UW-1:0]   m_user  [NC];
    bit [TW-1:0]   m_tagcnt, m_tag;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit [31:0] m_read(input logic [7:0] a);
        int ai;
        int ch;
        ai = int'(a);
        if (ai == 1) return 32'(m_pend | m_infl);
        if (ai == 2) return 32'(m_done);
        if (ai == 3) return 32'(m_err);
        if (ai == 4) return 32'(m_irqen);
        if (ai >= 16 && ai < 16 + 4 * NC) begin
            ch = (ai - 16) / 4;
            case (ai % 4)
                0:       return m_addr[ch];
                1:       return m_bytes[ch];
                2:       return (ch < NM) ? m_tuser[ch] : 32'h0;
                default: return 32'(m_code[ch]);
            endcase
        end
        return 32'h0;
    endfunction

    task automatic m_step();
        bit [NC-1:0]   rdy, sv, start, nd, ne;
        bit [4*NC-1:0] errs;
        bit [3:0]      code;
        int            ai, ch;
        rdy  = {s2mm_ready, mm2s_ready};
        sv   = {s2mm_status_valid, mm2s_status_valid};
        errs = {s2mm_status_error, mm2s_status_error};
        if (!rstn) begin
            m_pend = '0; m_infl = '0; m_done = '0; m_err = '0; m_irqen = '0;
            m_tagcnt = '0; m_tag = '0;
            for (int c = 0; c < NC; c++) begin
                m_addr[c] = 0; m_bytes[c] = 0; m_tuser[c] = 0; m_code[c] = 0;
                m_desc[c] = 0; m_user[c] = 0;
            end
            return;
        end
        start = (reg_wr_en && reg_wr_addr == 8'h00) ? reg_wr_data[NC-1:0] : '0;
        nd = m_done;
        ne = m_err;
        if (reg_wr_en && reg_wr_addr == 8'h02) nd &= ~reg_wr_data[NC-1:0];
        if (reg_wr_en && reg_wr_addr == 8'h03) ne &= ~reg_wr_data[NC-1:0];
        for (int c = 0; c < NC; c++) begin
            code = errs[c*4 +: 4];
            if (m_pend[c]) begin
                if (rdy[c]) begin
                    m_pend[c] = 1'b0;
                    m_infl[c] = 1'b1;
                    if (c >= NM) m_tagcnt++;
                end
            end else if (m_infl[c]) begin
                if (sv[c]) begin
                    m_infl[c] = 1'b0;
                    m_code[c] = code;
                    if (code == 4'h0) nd[c] = 1'b1;
                    else ne[c] = 1'b1;
                end
            end else if (start[c]) begin
                if (m_bytes[c] == 0) begin
                    ne[c]     = 1'b1;
                    m_code[c] = 4'hF;
                end else begin
                    m_pend[c] = 1'b1;
                    m_desc[c] = {m_bytes[c], m_addr[c]};
                    if (c < NM) m_user[c] = UW'(m_tuser[c]);
                    else m_tag = m_tagcnt;
                end
            end
        end
        m_done = nd;
        m_err  = ne;
        if (reg_wr_en) begin
            ai = int'(reg_wr_addr);
            if (ai == 4) m_irqen = reg_wr_data[NC-1:0];
            if (ai >= 16 && ai < 16 + 4 * NC) begin
                ch = (ai - 16) / 4;
                case (ai % 4)
                    0: m_addr[ch]  = reg_wr_data;
                    1: m_bytes[ch] = reg_wr_data;
                    2: if (ch < NM) m_tuser[ch] = reg_wr_data;
                    default: ;
                endcase
            end
        end
    endtask

    // Compare just before each rising edge, then advance the model through it.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            check("valid", {s2mm_valid, mm2s_valid}, m_pend);
            for (int c = 0; c < NM; c++) begin
                if (m_pend[c]) begin
                    check("mm2s_desc", mm2s_desc[c], m_desc[c]);
                    check("mm2s_user", mm2s_user[c], m_user[c]);
                end
            end
            if (m_pend[NC-1]) begin
                check("s2mm_desc", s2mm_desc[0], m_desc[NC-1]);
                check("s2mm_tag", s2mm_tag[0], m_tag);
            end
            check("irq", irq, |((m_done | m_err) & m_irqen));
            check("rd_data", reg_rd_data, m_read(reg_rd_addr));
            m_step();
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
        reg_wr_en         = 1'b0;
        mm2s_status_valid = '0;
        s2mm_status_valid = '0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        reg_wr_en   = 1'b1;
        reg_wr_addr = a;
        reg_wr_data = d;
        step();
    endtask

    task automatic rd_check(input logic [7:0] a, input logic [31:0] exp, input string name);
        reg_rd_addr = a;
        #1;
        check(name, reg_rd_data, exp);
    endtask

    initial begin
        rstn = 1'b0;
        reg_wr_en = 1'b0; reg_wr_addr = '0; reg_wr_data = '0; reg_rd_addr = '0;
        mm2s_ready = '0; mm2s_status_error = '0; mm2s_status_valid = '0;
        s2mm_ready = '0; s2mm_status_error = '0; s2mm_status_valid = '0;
        repeat (3) step();
        rstn = 1'b1;
        step();
        check("lit_reset_valid", {s2mm_valid, mm2s_valid}, 4'h0);
        check("lit_reset_irq", irq, 1'b0);
        rd_check(8'h01, 32'h0, "lit_reset_busy");

        // Basic MM2S0 transfer with back-pressure.
        wr(8'h10, 32'h1000);
        wr(8'h11, 32'h40);
        wr(8'h12, 32'h5);
        wr(8'h04, 32'hF);
        wr(8'h00, 32'h1);
        check("lit_valid_t1", mm2s_valid, 3'b001);
        check("lit_desc", mm2s_desc[0], 64'h00000040_00001000);
        check("lit_user", mm2s_user[0], 65'h5);
        step();
        step();
        step();
        mm2s_ready[0] = 1'b1;
        check("lit_valid_held", mm2s_valid[0], 1'b1);
        step();
        mm2s_ready[0] = 1'b0;
        check("lit_valid_drop", mm2s_valid[0], 1'b0);
        mm2s_status_valid[0] = 1'b1;
        step();
        rd_check(8'h02, 32'h1, "lit_done");
        check("lit_irq_set", irq, 1'b1);
        wr(8'h02, 32'h1);
        check("lit_irq_clr", irq, 1'b0);

        // S2MM: error completion then tags across three launches.
        wr(8'h1C, 32'h8000);
        wr(8'h1D, 32'h100);
        s2mm_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wr(8'h00, 32'h8);
            check("lit_s2mm_valid", s2mm_valid, 1'b1);
            check("lit_tag", s2mm_tag[0], TW'(k));
            step();
            s2mm_status_valid = 1'b1;
            s2mm_status_error[0] = (k == 0) ? 4'h2 : 4'h0;
            step();
            s2mm_status_error[0] = 4'h0;
            if (k == 0) begin
                rd_check(8'h03, 32'h8, "lit_err3");
                step();
                rd_check(8'h1F, 32'h2, "lit_errcode3");
                step();
                rd_check(8'h02, 32'h0, "lit_done3_clear");
                step();
            end
        end
        s2mm_ready = 1'b0;

        // Zero-length START on MM2S1.
        wr(8'h15, 32'h0);
        wr(8'h00, 32'h2);
        check("lit_zero_valid", mm2s_valid, 3'b000);
        rd_check(8'h03, 32'hA, "lit_zero_err");
        step();
        rd_check(8'h17, 32'hF, "lit_zero_code");
        step();

        // Shadowing and START-while-busy on MM2S0.
        wr(8'h00, 32'h1);
        wr(8'h10, 32'h2000);
        check("lit_shadow_desc", mm2s_desc[0], 64'h00000040_00001000);
        wr(8'h00, 32'h1);
        check("lit_busy_start", mm2s_desc[0], 64'h00000040_00001000);
        mm2s_ready[0] = 1'b1;
        step();
        mm2s_ready[0] = 1'b0;

        // W1C racing a hardware set of the same bit.
        mm2s_status_valid[0] = 1'b1;
        wr(8'h02, 32'h9);
        rd_check(8'h02, 32'h1, "lit_w1c_race");
        step();

        // Reset during WAIT, then a stale status.
        mm2s_ready[0] = 1'b1;
        wr(8'h00, 32'h1);
        step();
        mm2s_ready[0] = 1'b0;
        rstn = 1'b0;
        step();
        check("lit_rst_valid", {s2mm_valid, mm2s_valid}, 4'h0);
        check("lit_rst_irq", irq, 1'b0);
        rstn = 1'b1;
        mm2s_status_valid[0] = 1'b1;
        step();
        rd_check(8'h02, 32'h0, "lit_late_done");
        step();
        rd_check(8'h03, 32'h0, "lit_late_err");
        step();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rstn        = ($urandom_range(0, 399) != 0);
            reg_wr_en   = ($urandom_range(0, 2) == 0);
            reg_wr_data = $urandom;
            case ($urandom_range(0, 9))
                0, 1: begin
                    reg_wr_addr = 8'h00;
                    reg_wr_data = 32'($urandom_range(0, 15));
                end
                2: reg_wr_addr = 8'h02 + 8'($urandom_range(0, 1));
                3: reg_wr_addr = 8'h04;
                4, 5, 6, 7: begin
                    reg_wr_addr = 8'h10 + 8'($urandom_range(0, 4 * NC - 1));
                    if ($urandom_range(0, 3) == 0) reg_wr_data = 32'h0;
                end
                default: reg_wr_addr = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(5, 15))
                                                                   : 8'($urandom_range(32, 255));
            endcase
            mm2s_ready = 3'($urandom);
            s2mm_ready = 1'($urandom);
            for (int c = 0; c < NM; c++) begin
                mm2s_status_valid[c] = ($urandom_range(0, 2) == 0);
                mm2s_status_error[c] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            end
            s2mm_status_valid[0] = ($urandom_range(0, 2) == 0);
            s2mm_status_error[0] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            reg_rd_addr = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 35));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
